// File: rtl/cnn_kernel_ctrl_pkg.sv
// Shared widths, kernel geometry and FSM encoding for the CNN kernel controller.
// The MAC kernel sits beside the controller, so its operand widths live here too.
package cnn_kernel_ctrl_pkg;

  localparam int I_F_BW = 8;
  localparam int AK_BW  = 2 * I_F_BW + 4;
  localparam int KX     = 3;
  localparam int KY     = 3;
  localparam int D_BW   = 7;
  localparam int A_BW   = 14;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Linear tap index inside the 3x3 window, row-major.
  function automatic logic [3:0] tap_index(input logic [1:0] ky, input logic [1:0] kx);
    return 4'(ky) * 4'(KX) + 4'(kx);
  endfunction

endpackage

// File: rtl/cnn_kernel_ctrl.sv
// Streams 3x3 windows of a feature map out of memory into an external MAC kernel
// and forwards the kernel results as an indexed result stream.
module cnn_kernel_ctrl
  import cnn_kernel_ctrl_pkg::*;
(
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      i_run,
  input  logic [D_BW-1:0]           i_width,
  input  logic [D_BW-1:0]           i_height,
  output logic                      o_idle,
  output logic                      o_done,
  output logic                      o_rd_en,
  output logic [A_BW-1:0]           o_rd_addr,
  input  logic [I_F_BW-1:0]         i_rd_data,
  output logic                      o_soft_reset,
  output logic                      o_kernel_valid,
  output logic [KX*KY*I_F_BW-1:0]   o_kernel_fmap,
  input  logic                      i_kernel_valid,
  input  logic [AK_BW-1:0]          i_kernel_acc,
  output logic                      o_res_valid,
  output logic [A_BW-1:0]           o_res_addr,
  output logic [AK_BW-1:0]          o_res_data
);

  state_t state, state_next;

  logic [D_BW-1:0] width_q, height_q;
  logic            dims_ok;
  logic [1:0]      kx, ky;
  logic [D_BW-1:0] col, row;
  logic [A_BW-1:0] res_cnt;
  logic            rd_d1;
  logic [3:0]      tap_d1;

  logic            accept, issue, first_slot, last_read;
  logic            kx_last, ky_last, col_last, row_last;
  logic            res_take, res_final;
  logic [A_BW-1:0] rd_addr, res_total;

  assign accept     = (state == ST_IDLE) && i_run;
  assign issue      = (state == ST_RUN) && dims_ok;
  assign kx_last    = (kx == 2'(KX - 1));
  assign ky_last    = (ky == 2'(KY - 1));
  assign col_last   = (col == width_q - D_BW'(3));
  assign row_last   = (row == height_q - D_BW'(3));
  assign last_read  = issue && kx_last && ky_last && col_last && row_last;
  assign first_slot = (kx == 2'd0) && (ky == 2'd0) && (col == '0) && (row == '0);

  assign rd_addr   = (A_BW'(row) + A_BW'(ky)) * A_BW'(width_q) + A_BW'(col) + A_BW'(kx);
  assign res_total = (A_BW'(height_q) - A_BW'(2)) * (A_BW'(width_q) - A_BW'(2));
  assign res_take  = i_kernel_valid && dims_ok && ((state == ST_RUN) || (state == ST_DRAIN));
  assign res_final = res_take && (res_cnt == res_total - A_BW'(1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (i_run) state_next = ST_RUN;
      ST_RUN: begin
        if (!dims_ok)       state_next = ST_DONE;
        else if (last_read) state_next = ST_DRAIN;
      end
      ST_DRAIN: if (res_final) state_next = ST_DONE;
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    o_idle       = 1'b0;
    o_done       = 1'b0;
    o_rd_en      = 1'b0;
    o_soft_reset = 1'b0;
    o_rd_addr    = '0;
    case (state)
      ST_IDLE: o_idle = 1'b1;
      ST_RUN: begin
        o_rd_en      = dims_ok;
        o_soft_reset = first_slot;
        if (dims_ok) o_rd_addr = rd_addr;
      end
      ST_DONE: o_done = 1'b1;
      default: ;
    endcase
  end

  // Window walk: kx fastest, then ky, then column, then row; everything wraps to 0 on the last read.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      width_q  <= '0;
      height_q <= '0;
      dims_ok  <= 1'b0;
      kx       <= '0;
      ky       <= '0;
      col      <= '0;
      row      <= '0;
    end else if (accept) begin
      width_q  <= i_width;
      height_q <= i_height;
      dims_ok  <= (i_width >= D_BW'(3)) && (i_height >= D_BW'(3));
      kx       <= '0;
      ky       <= '0;
      col      <= '0;
      row      <= '0;
    end else if (issue) begin
      if (!kx_last) begin
        kx <= kx + 2'd1;
      end else begin
        kx <= '0;
        if (!ky_last) begin
          ky <= ky + 2'd1;
        end else begin
          ky <= '0;
          if (!col_last) begin
            col <= col + D_BW'(1);
          end else begin
            col <= '0;
            row <= row_last ? '0 : row + D_BW'(1);
          end
        end
      end
    end
  end

  // Read data lands one cycle after the strobe, so the tap index travels with it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_d1          <= 1'b0;
      tap_d1         <= '0;
      o_kernel_fmap  <= '0;
      o_kernel_valid <= 1'b0;
    end else begin
      rd_d1          <= issue;
      tap_d1         <= tap_index(ky, kx);
      o_kernel_valid <= rd_d1 && (tap_d1 == 4'(KX * KY - 1));
      for (int k = 0; k < KX * KY; k++) begin
        if (rd_d1 && (tap_d1 == 4'(k))) o_kernel_fmap[k*I_F_BW +: I_F_BW] <= i_rd_data;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      res_cnt     <= '0;
      o_res_valid <= 1'b0;
      o_res_addr  <= '0;
      o_res_data  <= '0;
    end else begin
      o_res_valid <= res_take;
      if (accept) begin
        res_cnt <= '0;
      end else if (res_take) begin
        res_cnt    <= res_cnt + A_BW'(1);
        o_res_addr <= res_cnt;
        o_res_data <= i_kernel_acc;
      end
    end
  end

endmodule

// File: doc/cnn_kernel_ctrl.md
CNN_KERNEL_CTRL -- requirements
Module: cnn_kernel_ctrl

Interface
REQ-001 SHALL take parameters from defines_cnn_core.vh: I_F_BW (8), AK_BW (accumulator width), KX/KY (3), D_BW (7, dimension width), A_BW (14, address width).
REQ-002 SHALL have these ports:
- clk  in  1  single clock.
- reset_n  in  1  asynchronous active-low reset.
- i_run  in  1  start pulse.
- i_width / i_height  in  D_BW  fmap columns/rows, latched at start.
- o_idle  out  1  high in IDLE.
- o_done  out  1  one-cycle completion pulse.
- o_rd_en  out  1  fmap memory read strobe.
- o_rd_addr  out  A_BW  fmap read address.
- i_rd_data  in  I_F_BW  read data, valid exactly 1 cycle after o_rd_en.
- o_soft_reset  out  1  drives the MAC kernel soft reset.
- o_kernel_valid  out  1  drives the MAC kernel input valid.
- o_kernel_fmap  out  KX*KY*I_F_BW  3x3 window to the MAC kernel.
- i_kernel_valid  in  1  MAC kernel output valid.
- i_kernel_acc  in  AK_BW  MAC kernel result.
- o_res_valid  out  1  result strobe.
- o_res_addr  out  A_BW  result index.
- o_res_data  out  AK_BW  result value.

Function
REQ-003 SHALL implement FSM IDLE -> RUN -> DRAIN -> DONE -> IDLE.
REQ-004 SHALL accept i_run only in IDLE; i_run SHALL be ignored in any other state.
- Dimensions SHALL be latched on acceptance; the next state is RUN.
- If the latched width < 3 or height < 3, the next state SHALL be DONE; no reads and no results occur.
REQ-005 SHALL assert o_soft_reset for exactly the first RUN cycle.
REQ-006 SHALL compute valid convolution (stride 1, no padding) with OH = H-2 and OW = W-2.
- Outputs SHALL be produced row-major: r = 0..OH-1, c = 0..OW-1.
REQ-007 SHALL, for each output, issue 9 reads in consecutive cycles: ky = 0..2 outer, kx = 0..2 inner, addr = (r+ky)*W + (c+kx).
- Reads SHALL continue back-to-back across windows, with no bubble, from the first RUN cycle.
REQ-008 SHALL capture the data of tap k = ky*3+kx into o_kernel_fmap[k*I_F_BW +: I_F_BW].
REQ-009 SHALL assert o_kernel_valid for one cycle, 2 cycles after the 9th read of a window is issued.
- o_kernel_fmap SHALL be stable during that cycle; one valid pulse occurs every 9 cycles.
REQ-010 SHALL enter DRAIN the cycle after the last read of the last window.
REQ-011 SHALL, for each i_kernel_valid, register o_res_valid=1, o_res_data=i_kernel_acc and o_res_addr=result count on the next cycle.
- The result count starts at 0 and increments per result.
REQ-012 SHALL enter DONE on the cycle the final (OH*OW-th) result is registered; DONE lasts one cycle with o_done=1, then returns to IDLE.
REQ-013 SHALL hold o_rd_en=0 and o_kernel_valid=0 outside RUN/DRAIN issue slots.
- An i_kernel_valid received in IDLE SHALL be ignored.
REQ-014 SHALL compute all address arithmetic in A_BW bits; H*W SHALL not exceed 2^A_BW (caller guarantee).

Reset
REQ-015 SHALL, on reset_n low at any time including mid-run, asynchronously force:
- state = IDLE, all counters = 0;
- o_idle = 1;
- all other outputs = 0, o_kernel_fmap = 0.
REQ-016 SHALL begin normal operation on the first clk edge after reset_n deasserts; no partial job resumes.

Structure
REQ-017 SHALL add D_BW, A_BW and the FSM state encodings to defines_cnn_core.vh.
- I_F_BW, AK_BW, KX and KY SHALL be reused from the same file.
REQ-018 SHALL be a single module with one counter set (kx, ky, c, r, result count) and one window register.
- cnn_kernel SHALL NOT be instantiated inside; it is connected at the parent level.

Verification
REQ-019 A 4x4 image with pixel = address and i_run at cycle 0 SHALL produce:
- reads at cycles 1-36;
- o_kernel_valid at cycles 11, 20, 29, 38;
- window 0 = pixels {0,1,2,4,5,6,8,9,10}.
REQ-020 The same bench with the real cnn_kernel and all weights = 1 SHALL produce:
- o_res_valid at cycles 14, 23, 32, 41 with addr 0..3 and data 45, 54, 81, 90;
- o_done at cycle 41.
REQ-021 i_width = 2, i_height = 5 SHALL produce o_done 2 cycles after i_run, with no o_rd_en and no o_res_valid.
REQ-022 i_run re-pulsed at cycle 15 of a 4x4 job SHALL leave the read and result sequence identical to REQ-019 and REQ-020.
REQ-023 reset_n low at cycle 20 of a 4x4 job SHALL drop all outputs to 0 immediately with o_idle=1.
- A new i_run after reset SHALL complete with correct results.
REQ-024 A 5x3 image SHALL produce 3 results at addr 0..2 for windows c = 0..2, with read addresses for c=2 of 2,3,4,7,8,9,12,13,14.
